reloj_soc_timer_mc: RTL and testbench

//   Multi-channel interval timer on an Avalon-MM slave with a 16-bit data bus.

---
 rtl/reloj_soc_timer_mc_if.sv | 12 +
 rtl/reloj_soc_timer_mc.sv | 167 ++++++++++++++++
 tb/tb_reloj_soc_timer_mc.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reloj_soc_timer_mc_if.sv
// Avalon-MM slave bus bundle for reloj_soc_timer_mc.
// The CPU side uses the master modport and the timer uses the slave modport.
interface reloj_soc_timer_mc_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/reloj_soc_timer_mc.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave.
// Each channel has the following state:
//   - period and counter registers
//   - run/stop control
//   - one-shot or continuous mode
//   - a counter snapshot
//   - a sticky timeout flag with an interrupt enable
// Optional per-channel prescaler is built when TIMER_PRESCALER_EN is defined.
module reloj_soc_timer_mc #(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'hC34F
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reloj_soc_timer_mc_if.slave  bus,
  output logic                 irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];

  logic                    wr;
  logic [1:0]              ch_sel;
  logic [2:0]              reg_sel;
  logic [NUM_CH-1:0][15:0] ch_rd;
  logic [NUM_CH-1:0]       irq_vec;
  logic [15:0]             rd_mux;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign ch_sel  = bus.address[4:3];
  assign reg_sel = bus.address[2:0];
  assign irq     = |irq_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snap;
    logic             run;
    logic             to;
    logic             cont;
    logic             ito;
    logic             force_reload;
    logic             sel;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_per;
    logic             wr_snap;
    logic             tick;
    logic             timeout;
    logic [31:0]      period_ext;
    logic [31:0]      snap_ext;
    logic [31:0]      period_next;
    logic [15:0]      presc_rd;

    assign sel        = wr && (ch_sel == 2'(c));
    assign wr_status  = sel && (reg_sel == 3'd0);
    assign wr_ctrl    = sel && (reg_sel == 3'd1);
    assign wr_per     = sel && ((reg_sel == 3'd2) || (reg_sel == 3'd3));
    assign wr_snap    = sel && ((reg_sel == 3'd4) || (reg_sel == 3'd5));
    assign timeout    = run && tick && !force_reload && (cnt == '0);
    assign period_ext = 32'(period);
    assign snap_ext   = 32'(snap);
    assign irq_vec[c] = to & ito;

`ifdef TIMER_PRESCALER_EN
    logic        wr_presc;
    logic        restart;
    logic [15:0] presc;
    logic [15:0] pcnt;

    assign wr_presc = sel && (reg_sel == 3'd6);
    assign restart  = wr_per || (wr_ctrl && (bus.writedata[3] || bus.writedata[2]));
    assign tick     = run && (pcnt == 16'd0);
    assign presc_rd = presc;

    // Prescaler: counts down while running and re-arms on every tick or control event.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        presc <= 16'd0;
        pcnt  <= 16'd0;
      end else begin
        if (wr_presc) begin
          presc <= bus.writedata;
          pcnt  <= bus.writedata;
        end else if (restart || tick) begin
          pcnt <= presc;
        end else if (run) begin
          pcnt <= pcnt - 16'd1;
        end
      end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = 16'd0;
`endif

    // Merge the PERL/PERH halves into a full-width period candidate.
    always_comb begin
      period_next = period_ext;
      if (reg_sel == 3'd2) period_next[15:0]  = bus.writedata;
      if (reg_sel == 3'd3) period_next[31:16] = bus.writedata;
    end

    // Channel state: counting, reload, flags, control and snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt          <= RST_PERIOD;
        period       <= RST_PERIOD;
        snap         <= '0;
        run          <= 1'b0;
        to           <= 1'b0;
        cont         <= 1'b0;
        ito          <= 1'b0;
        force_reload <= 1'b0;
      end else begin
        force_reload <= wr_per;
        if (wr_per) period <= period_next[CNT_W-1:0];
        if (wr_snap) snap <= cnt;
        if (force_reload) begin
          cnt <= period;
        end else if (run && tick) begin
          cnt <= (cnt == '0) ? period : cnt - CNT_W'(1);
        end
        if (timeout) to <= 1'b1;
        else if (wr_status) to <= 1'b0;
        if (timeout) run <= cont;
        if (wr_ctrl) begin
          cont <= bus.writedata[1];
          ito  <= bus.writedata[0];
          if (bus.writedata[3]) run <= 1'b0;
          else if (bus.writedata[2]) run <= 1'b1;
        end
        if (wr_per) run <= 1'b0;
      end
    end

    // Per-channel register read view; control strobes always read back as 0.
    always_comb begin
      ch_rd[c] = 16'h0000;
      case (reg_sel)
        3'd0:    ch_rd[c] = {14'b0, run, to};
        3'd1:    ch_rd[c] = {14'b0, cont, ito};
        3'd2:    ch_rd[c] = period_ext[15:0];
        3'd3:    ch_rd[c] = period_ext[31:16];
        3'd4:    ch_rd[c] = snap_ext[15:0];
        3'd5:    ch_rd[c] = snap_ext[31:16];
        3'd6:    ch_rd[c] = presc_rd;
        default: ch_rd[c] = 16'h0000;
      endcase
    end
  end

  // Channel select for the read path; absent channels read as zero.
  always_comb begin
    rd_mux = 16'h0000;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 2'(c)) rd_mux = ch_rd[c];
    end
  end

  // One-cycle registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= 16'h0000;
    else          bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_reloj_soc_timer_mc.sv
// Self-checking bench for reloj_soc_timer_mc (NUM_CH=2, CNT_W=32).
// Register reads are checked through a scoreboard queue.
// Prescaler checks follow TIMER_PRESCALER_EN.
module tb_reloj_soc_timer_mc;
  logic clk;
  logic reset_n;
  logic irq;
  int   checks;
  int   errors;

  typedef struct {
    logic        is_write;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  reloj_soc_timer_mc_if bus();

  reloj_soc_timer_mc #(.NUM_CH(2), .CNT_W(32), .DEFAULT_PERIOD(32'hC34F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one value and keep the counters
  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end
  endtask

  // One bus cycle starting and ending on a falling edge
  task automatic apply_stimulus(input logic is_write, input logic [4:0] addr, input logic [15:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = ~is_write;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Read with the expected value routed through the scoreboard
  task automatic read_check(input logic [4:0] addr, input logic [15:0] exp, input string name);
    sb_t e;
    sbq.push_back('{name, exp});
    apply_stimulus(1'b0, addr, 16'h0000);
    e = sbq.pop_front();
    check_output(e.name, bus.readdata, e.exp);
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [15:0] data);
    apply_stimulus(1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_irq(input string name, input logic exp);
    check_output(name, {15'b0, irq}, {15'b0, exp});
  endtask

  initial begin
    int  n;
    bit  seen;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.address = 5'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 16'h0000;
    idle(3);
    check_output("reset_readdata", bus.readdata, 16'h0000);
    check_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: reset values, register readback, decode holes
    vecs.push_back('{1'b0, 5'h00, 16'h0000, 16'h0000, "rst_status"});
    vecs.push_back('{1'b0, 5'h02, 16'h0000, 16'hC34F, "rst_perl"});
    vecs.push_back('{1'b0, 5'h03, 16'h0000, 16'h0000, "rst_perh"});
    vecs.push_back('{1'b0, 5'h01, 16'h0000, 16'h0000, "rst_ctrl"});
    vecs.push_back('{1'b0, 5'h0A, 16'h0000, 16'hC34F, "rst_perl_ch1"});
    vecs.push_back('{1'b0, 5'h04, 16'h0000, 16'h0000, "rst_snapl"});
    vecs.push_back('{1'b1, 5'h02, 16'h1234, 16'h0000, ""});
    vecs.push_back('{1'b1, 5'h03, 16'hABCD, 16'h0000, ""});
    vecs.push_back('{1'b0, 5'h02, 16'h0000, 16'h1234, "perl_rb"});
    vecs.push_back('{1'b0, 5'h03, 16'h0000, 16'hABCD, "perh_rb"});
    vecs.push_back('{1'b1, 5'h05, 16'h0000, 16'h0000, ""});
    vecs.push_back('{1'b0, 5'h05, 16'h0000, 16'hABCD, "snaph_reload"});
    vecs.push_back('{1'b0, 5'h04, 16'h0000, 16'h1234, "snapl_reload"});
    vecs.push_back('{1'b1, 5'h01, 16'h000F, 16'h0000, ""});
    vecs.push_back('{1'b0, 5'h01, 16'h0000, 16'h0003, "ctrl_rb"});
    vecs.push_back('{1'b0, 5'h00, 16'h0000, 16'h0000, "stop_wins_status"});
    vecs.push_back('{1'b1, 5'h01, 16'h0000, 16'h0000, ""});
    vecs.push_back('{1'b0, 5'h07, 16'h0000, 16'h0000, "addr7"});
    vecs.push_back('{1'b1, 5'h1A, 16'h5555, 16'h0000, ""});
    vecs.push_back('{1'b0, 5'h1A, 16'h0000, 16'h0000, "ch3_perl"});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_write) bus_write(vecs[i].addr, vecs[i].data);
      else read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // Continuous channel 0, period 3
    bus_write(5'h02, 16'h0003);
    bus_write(5'h03, 16'h0000);
    bus_write(5'h01, 16'h0007);
    check_irq("c2_irq_start", 1'b0);
    idle(3);
    check_irq("c2_irq_before_to", 1'b0);
    idle(1);
    check_irq("c2_irq_to", 1'b1);
    bus_write(5'h04, 16'h0000);
    read_check(5'h04, 16'h0003, "c2_reload_snap");
    bus_write(5'h00, 16'h0000);
    check_irq("c2_irq_cleared", 1'b0);
    idle(1);
    check_irq("c2_irq_second_to", 1'b1);
    bus_write(5'h01, 16'h0008);
    bus_write(5'h00, 16'h0000);
    check_irq("c2_irq_stopped", 1'b0);
    read_check(5'h00, 16'h0000, "c2_status_stopped");

    // STATUS write on the timeout edge, start+stop together
    bus_write(5'h02, 16'h0003);
    bus_write(5'h01, 16'h0007);
    idle(3);
    bus_write(5'h00, 16'h0000);
    check_irq("c5_irq_to_wins", 1'b1);
    read_check(5'h00, 16'h0003, "c5_status_to_wins");
    bus_write(5'h01, 16'h000C);
    read_check(5'h00, 16'h0001, "c5_status_stop_wins");
    bus_write(5'h00, 16'h0000);
    read_check(5'h1F, 16'h0000, "c5_ch3_addr7");

    // One-shot channel 1, period 2
    bus_write(5'h0A, 16'h0002);
    bus_write(5'h0B, 16'h0000);
    bus_write(5'h09, 16'h0005);
    idle(2);
    check_irq("c3_irq_before_to", 1'b0);
    idle(1);
    check_irq("c3_irq_to", 1'b1);
    read_check(5'h08, 16'h0001, "c3_status_oneshot");
    bus_write(5'h08, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check_output("c3_no_more_to", {15'b0, seen}, 16'h0000);
    read_check(5'h08, 16'h0000, "c3_status_idle");
    bus_write(5'h0C, 16'h0000);
    read_check(5'h0C, 16'h0002, "c3_snapl_reloaded");
    read_check(5'h0D, 16'h0000, "c3_snaph");

    // 17-bit period and snapshot of a running count
    bus_write(5'h03, 16'h0001);
    bus_write(5'h02, 16'h0000);
    bus_write(5'h01, 16'h0004);
    idle(5);
    bus_write(5'h04, 16'h0000);
    read_check(5'h04, 16'hFFFB, "c4_snapl");
    read_check(5'h05, 16'h0000, "c4_snaph");
    read_check(5'h03, 16'h0001, "c4_perh");
    bus_write(5'h01, 16'h0008);

`ifdef TIMER_PRESCALER_EN
    // Prescaler 4, period 1: one timeout every 10 clocks
    bus_write(5'h06, 16'h0004);
    read_check(5'h06, 16'h0004, "c6_presc_rb");
    bus_write(5'h02, 16'h0001);
    bus_write(5'h03, 16'h0000);
    bus_write(5'h01, 16'h0007);
    n = 0;
    while (!irq && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_irq("c6_first_to", 1'b1);
    bus_write(5'h00, 16'h0000);
    n = 0;
    while (!irq && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("c6_interval", 16'(n), 16'd9);
    bus_write(5'h01, 16'h0008);
`else
    bus_write(5'h06, 16'h0004);
    read_check(5'h06, 16'h0000, "c6_presc_absent");
`endif

    // Asynchronous reset mid-operation
    bus_write(5'h01, 16'h0007);
    #2 reset_n = 1'b0;
    #1 check_output("async_rst_readdata", bus.readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_check(5'h00, 16'h0000, "post_rst_status");
    read_check(5'h02, 16'hC34F, "post_rst_perl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
